jtag_dbg_cmd: RTL and testbench
===============================

// Module: jtag_dbg_cmd
// PURPOSE
//  Debug command engine downstream of the JTAG register port (reg_update/reg_q/reg_addr_q).
//  Assembles host-written bytes into 32-bit address/data, issues one read/write bus request,
//  captures the response and returns status/read data on reg_d/reg_addr_d. Runs entirely in jtck domain.
// PARAMETERS
//  TIMEOUT  255  max jtck cycles from request issue to response before abort (1..65535)
// PORTS
//  jtck        in   1   JTAG clock; sole clock of the block
//  jrstn       in   1   asynchronous active-low reset
//  reg_update  in   1   one-cycle strobe: reg_q/reg_addr_q valid
//  reg_q       in   8   byte written by host
//  reg_addr_q  in   3   register select for reg_q
//  reg_d       out  8   byte returned to host
//  reg_addr_d  out  3   register id of reg_d contents
//  req_valid   out  1   bus request valid
//  req_ready   in   1   bus request accepted
//  req_we      out  1   1=write, 0=read
//  req_addr    out  32  request address
//  req_wdata   out  32  write data
//  rsp_valid   in   1   one-cycle response strobe
//  rsp_rdata   in   32  read data, valid with rsp_valid
//  rsp_err     in   1   bus error, valid with rsp_valid
// BEHAVIOUR
//  Reset: all outputs 0; addr_sr, wdata_sr, rdata, status, timeout counter 0; FSM=IDLE.
//  Register map (on reg_update):
//   addr 1: addr_sr  <= {addr_sr[23:0], reg_q}  (MSB byte first)
//   addr 2: wdata_sr <= {wdata_sr[23:0], reg_q}
//   addr 3: reg_d <= rdata byte reg_q[1:0] (0=LSB), reg_addr_d <= 3
//   addr 0: command: 8'h01 READ, 8'h02 WRITE, 8'h04 ABORT, 8'h08 CLRSTAT; other -> set ERR
//   addr 4-7: ignored, no state change
//  Status byte = {BUSY, DONE, ERR, TMO, OVR, BUSERR, LAST[1:0]}; LAST=1 read, 2 write.
//  reg_d/reg_addr_d registered; after any reg_update other than addr 3, and on every status
//   change, reg_d <= status, reg_addr_d <= 0. Addr-3 selection holds until next reg_update.
//  FSM: IDLE -> REQ -> RSP -> IDLE.
//   IDLE: READ/WRITE at cycle N -> REQ, req_valid=1 at N+1, req_addr=addr_sr, req_wdata=wdata_sr,
//    req_we per cmd; BUSY=1, DONE/ERR/TMO/BUSERR cleared, LAST updated, counter=0.
//   REQ: req_valid and req_addr/req_we/req_wdata held stable until req_ready; on req_ready ->
//    RSP, req_valid=0 next cycle.
//   RSP: on rsp_valid -> IDLE, BUSY=0, DONE=1, BUSERR=rsp_err; rdata<=rsp_rdata for reads only.
//   Counter increments every cycle in REQ/RSP; reaching TIMEOUT -> IDLE, BUSY=0, TMO=1, ERR=1.
//   req_ready or rsp_valid in the same cycle as timeout: handshake wins, no timeout.
//  While BUSY: writes to addr 1/2 and READ/WRITE commands ignored and set OVR.
//  ABORT: any state -> IDLE next cycle, req_valid=0, BUSY=0, DONE=0; legal even mid-REQ.
//  CLRSTAT: clears DONE/ERR/TMO/OVR/BUSERR; BUSY and LAST unchanged; accepted while busy.
//  rsp_valid outside RSP ignored. reg_update and rsp_valid same cycle: both take effect.
//  jrstn assertion mid-transaction: immediate return to reset values, req_valid drops async.
// TESTING
//  T1 write: addr1 12,34,56,78; addr2 DE,AD,BE,EF; cmd 02; req_ready after 3 cycles, rsp 5 later
//     -> req_addr=32'h12345678, req_wdata=32'hDEADBEEF, req_we=1; final status 8'h42.
//  T2 read: cmd 01, rsp_rdata=32'hCAFEF00D -> status 8'h41; addr3 q=0 -> reg_d=8'h0D, reg_addr_d=3;
//     addr3 q=3 -> reg_d=8'hCA.
//  T3 timeout: TIMEOUT=8, cmd 01, req_ready never -> req_valid 8 cycles then 0; status 8'h31.
//  T4 overrun/abort: cmd 01, addr1 write while BUSY -> OVR=1, addr_sr unchanged; cmd 04 -> IDLE,
//     req_valid=0; cmd 08 -> status 8'h01.
//  T5 bus error/edges: rsp_err=1 -> BUSERR=1, DONE=1; stray rsp_valid in IDLE -> no change;
//     bad cmd 8'h10 -> ERR=1; jrstn pulse in REQ -> all outputs 0.

Source files
------------

// File: rtl/jtag_dbg_cmd_if.sv
// Bus side of the JTAG debug command engine: one outstanding request,
// accepted with req_ready, answered by a single-cycle rsp_valid strobe.
interface jtag_dbg_cmd_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/jtag_dbg_cmd.sv
// Debug command engine behind the JTAG register port: assembles address/data
// bytes, issues one bus request, and reports status or read data back to the host.
module jtag_dbg_cmd #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           jtck,
  input  logic           jrstn,
  input  logic           reg_update,
  input  logic [7:0]     reg_q,
  input  logic [2:0]     reg_addr_q,
  output logic [7:0]     reg_d,
  output logic [2:0]     reg_addr_d,
  jtag_dbg_cmd_if.master bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

  localparam logic [7:0]  CMD_READ  = 8'h01;
  localparam logic [7:0]  CMD_WRITE = 8'h02;
  localparam logic [7:0]  CMD_ABORT = 8'h04;
  localparam logic [7:0]  CMD_CLR   = 8'h08;
  localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT - 1);

  state_t      r_state;
  logic [15:0] r_cnt;
  logic [31:0] r_addr_sr;
  logic [31:0] r_wdata_sr;
  logic [31:0] r_rdata;
  logic [31:0] r_req_addr;
  logic [31:0] r_req_wdata;
  logic        r_req_we;
  logic        r_done;
  logic        r_err;
  logic        r_tmo;
  logic        r_ovr;
  logic        r_buserr;
  logic [1:0]  r_last;
  logic [7:0]  r_reg_d;
  logic [2:0]  r_reg_addr_d;
  logic        r_sel3;

  state_t      w_state_next;
  logic [15:0] w_cnt_next;
  logic [31:0] w_addr_sr_next;
  logic [31:0] w_wdata_sr_next;
  logic [31:0] w_rdata_next;
  logic [31:0] w_req_addr_next;
  logic [31:0] w_req_wdata_next;
  logic        w_req_we_next;
  logic        w_done_next;
  logic        w_err_next;
  logic        w_tmo_next;
  logic        w_ovr_next;
  logic        w_buserr_next;
  logic [1:0]  w_last_next;
  logic [7:0]  w_status_next;
  logic [7:0]  w_reg_d_next;
  logic [2:0]  w_reg_addr_d_next;
  logic        w_sel3_next;

  logic        w_busy;
  logic        w_cmd;
  logic        w_cmd_rw;
  logic        w_issue;
  logic        w_abort;
  logic        w_clr;
  logic        w_badcmd;
  logic        w_wr_addr;
  logic        w_wr_wdata;
  logic        w_ovr_set;
  logic        w_cnt_hit;
  logic [7:0]  w_rdata_byte [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_rbyte
      assign w_rdata_byte[gi] = r_rdata[8*gi +: 8];
    end
  endgenerate

  assign w_busy     = (r_state != ST_IDLE);
  assign w_cmd      = reg_update && (reg_addr_q == 3'd0);
  assign w_cmd_rw   = (reg_q == CMD_READ) || (reg_q == CMD_WRITE);
  assign w_issue    = w_cmd && w_cmd_rw && !w_busy;
  assign w_abort    = w_cmd && (reg_q == CMD_ABORT);
  assign w_clr      = w_cmd && (reg_q == CMD_CLR);
  assign w_badcmd   = w_cmd && !w_cmd_rw && (reg_q != CMD_ABORT) && (reg_q != CMD_CLR);
  assign w_wr_addr  = reg_update && (reg_addr_q == 3'd1);
  assign w_wr_wdata = reg_update && (reg_addr_q == 3'd2);
  assign w_ovr_set  = w_busy && (w_wr_addr || w_wr_wdata || (w_cmd && w_cmd_rw));
  // Compare with >= so a counter that slipped past the limit still aborts.
  assign w_cnt_hit  = (r_cnt >= CNT_LAST);

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_addr_sr_next    = r_addr_sr;
    w_wdata_sr_next   = r_wdata_sr;
    w_rdata_next      = r_rdata;
    w_req_addr_next   = r_req_addr;
    w_req_wdata_next  = r_req_wdata;
    w_req_we_next     = r_req_we;
    w_done_next       = r_done;
    w_err_next        = r_err;
    w_tmo_next        = r_tmo;
    w_ovr_next        = r_ovr;
    w_buserr_next     = r_buserr;
    w_last_next       = r_last;
    w_status_next     = 8'h00;
    w_reg_d_next      = r_reg_d;
    w_reg_addr_d_next = r_reg_addr_d;
    w_sel3_next       = r_sel3;

    // Clear first so a completion in the same cycle still reports DONE.
    if (w_clr) begin
      w_done_next   = 1'b0;
      w_err_next    = 1'b0;
      w_tmo_next    = 1'b0;
      w_ovr_next    = 1'b0;
      w_buserr_next = 1'b0;
    end

    if (w_wr_addr && !w_busy) begin
      w_addr_sr_next = {r_addr_sr[23:0], reg_q};
    end
    if (w_wr_wdata && !w_busy) begin
      w_wdata_sr_next = {r_wdata_sr[23:0], reg_q};
    end

    case (r_state)
      ST_IDLE: begin
        if (w_issue) begin
          w_state_next     = ST_REQ;
          w_cnt_next       = 16'd0;
          w_done_next      = 1'b0;
          w_err_next       = 1'b0;
          w_tmo_next       = 1'b0;
          w_buserr_next    = 1'b0;
          w_last_next      = (reg_q == CMD_READ) ? 2'd1 : 2'd2;
          w_req_we_next    = (reg_q == CMD_WRITE);
          w_req_addr_next  = r_addr_sr;
          w_req_wdata_next = r_wdata_sr;
        end
      end
      ST_REQ: begin
        w_cnt_next = r_cnt + 16'd1;
        if (bus.req_ready) begin
          w_state_next = ST_RSP;
        end else if (w_cnt_hit) begin
          w_state_next = ST_IDLE;
          w_tmo_next   = 1'b1;
          w_err_next   = 1'b1;
        end
      end
      ST_RSP: begin
        w_cnt_next = r_cnt + 16'd1;
        if (bus.rsp_valid) begin
          w_state_next  = ST_IDLE;
          w_done_next   = 1'b1;
          w_buserr_next = bus.rsp_err;
          if (!r_req_we) begin
            w_rdata_next = bus.rsp_rdata;
          end
        end else if (w_cnt_hit) begin
          w_state_next = ST_IDLE;
          w_tmo_next   = 1'b1;
          w_err_next   = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    if (w_ovr_set) begin
      w_ovr_next = 1'b1;
    end
    if (w_badcmd) begin
      w_err_next = 1'b1;
    end
    if (w_abort) begin
      w_state_next = ST_IDLE;
      w_done_next  = 1'b0;
    end

    w_status_next = {(w_state_next != ST_IDLE), w_done_next, w_err_next, w_tmo_next,
                     w_ovr_next, w_buserr_next, w_last_next};

    // Read-data selection is sticky until the host touches any other register.
    if (reg_update && (reg_addr_q == 3'd3)) begin
      w_sel3_next       = 1'b1;
      w_reg_d_next      = w_rdata_byte[reg_q[1:0]];
      w_reg_addr_d_next = 3'd3;
    end else if (reg_update || !r_sel3) begin
      w_sel3_next       = 1'b0;
      w_reg_d_next      = w_status_next;
      w_reg_addr_d_next = 3'd0;
    end
  end

  always_ff @(posedge jtck or negedge jrstn) begin
    if (!jrstn) begin
      r_state      <= ST_IDLE;
      r_cnt        <= 16'd0;
      r_addr_sr    <= 32'd0;
      r_wdata_sr   <= 32'd0;
      r_rdata      <= 32'd0;
      r_req_addr   <= 32'd0;
      r_req_wdata  <= 32'd0;
      r_req_we     <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_tmo        <= 1'b0;
      r_ovr        <= 1'b0;
      r_buserr     <= 1'b0;
      r_last       <= 2'd0;
      r_reg_d      <= 8'd0;
      r_reg_addr_d <= 3'd0;
      r_sel3       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_addr_sr    <= w_addr_sr_next;
      r_wdata_sr   <= w_wdata_sr_next;
      r_rdata      <= w_rdata_next;
      r_req_addr   <= w_req_addr_next;
      r_req_wdata  <= w_req_wdata_next;
      r_req_we     <= w_req_we_next;
      r_done       <= w_done_next;
      r_err        <= w_err_next;
      r_tmo        <= w_tmo_next;
      r_ovr        <= w_ovr_next;
      r_buserr     <= w_buserr_next;
      r_last       <= w_last_next;
      r_reg_d      <= w_reg_d_next;
      r_reg_addr_d <= w_reg_addr_d_next;
      r_sel3       <= w_sel3_next;
    end
  end

  assign reg_d         = r_reg_d;
  assign reg_addr_d    = r_reg_addr_d;
  assign bus.req_valid = (r_state == ST_REQ);
  assign bus.req_we    = r_req_we;
  assign bus.req_addr  = r_req_addr;
  assign bus.req_wdata = r_req_wdata;

endmodule

// File: tb/tb_jtag_dbg_cmd.sv
// Directed bench for jtag_dbg_cmd: a transaction-level model predicts outputs
// every cycle, and literal checks pin the model to hand-computed results.
module tb_jtag_dbg_cmd;
  localparam int unsigned TMO = 8;

  logic       jtck = 1'b0;
  logic       jrstn;
  logic       reg_update;
  logic [7:0] reg_q;
  logic [2:0] reg_addr_q;
  logic [7:0] reg_d;
  logic [2:0] reg_addr_d;

  int n_cmp = 0;
  int n_bad = 0;

  jtag_dbg_cmd_if bus_if ();

  jtag_dbg_cmd #(.TIMEOUT(TMO)) dut (
    .jtck       (jtck),
    .jrstn      (jrstn),
    .reg_update (reg_update),
    .reg_q      (reg_q),
    .reg_addr_q (reg_addr_q),
    .reg_d      (reg_d),
    .reg_addr_d (reg_addr_d),
    .bus        (bus_if.master)
  );

  always #5 jtck = ~jtck;

  // phase: 0 nothing outstanding, 1 waiting for accept, 2 waiting for response
  typedef struct packed {
    logic [1:0]  phase;
    logic [31:0] age;
    logic        done, err, tmo, ovr, buserr;
    logic [1:0]  last;
    logic [31:0] addr, wdata, rdata, req_addr, req_wdata;
    logic        we;
    logic        sel3;
    logic [7:0]  rd_byte;
  } mdl_t;

  mdl_t m;

  function automatic logic [7:0] mstatus(input mdl_t s);
    return {(s.phase != 2'd0), s.done, s.err, s.tmo, s.ovr, s.buserr, s.last};
  endfunction

  function automatic mdl_t step(input mdl_t s, input logic upd, input logic [2:0] a,
                                input logic [7:0] q, input logic rdy, input logic rv,
                                input logic [31:0] rd, input logic re);
    mdl_t n = s;
    logic busy = (s.phase != 2'd0);
    logic cmd = upd && (a == 3'd0);
    logic [31:0] sh;
    if (cmd && q == 8'h08) begin
      n.done = 0; n.err = 0; n.tmo = 0; n.ovr = 0; n.buserr = 0;
    end
    if (busy) begin
      n.age = s.age + 1;
      if (s.phase == 2'd1 && rdy) n.phase = 2'd2;
      else if (s.phase == 2'd2 && rv) begin
        n.phase = 2'd0; n.done = 1; n.buserr = re;
        if (!s.we) n.rdata = rd;
      end else if (n.age >= TMO) begin
        n.phase = 2'd0; n.tmo = 1; n.err = 1;
      end
    end
    if (upd && (a == 3'd1 || a == 3'd2)) begin
      if (busy) n.ovr = 1;
      else if (a == 3'd1) n.addr = {s.addr[23:0], q};
      else n.wdata = {s.wdata[23:0], q};
    end
    if (cmd) begin
      case (q)
        8'h01, 8'h02: begin
          if (busy) n.ovr = 1;
          else begin
            n.phase = 2'd1; n.age = 0;
            n.done = 0; n.err = 0; n.tmo = 0; n.buserr = 0;
            n.we = (q == 8'h02); n.last = (q == 8'h01) ? 2'd1 : 2'd2;
            n.req_addr = s.addr; n.req_wdata = s.wdata;
          end
        end
        8'h04: begin n.phase = 2'd0; n.done = 0; end
        8'h08: ;
        default: n.err = 1;
      endcase
    end
    if (upd) begin
      if (a == 3'd3) begin
        sh = s.rdata >> (8 * int'(q[1:0]));
        n.sel3 = 1; n.rd_byte = sh[7:0];
      end else n.sel3 = 0;
    end
    return n;
  endfunction

  always @(posedge jtck or negedge jrstn) begin
    if (!jrstn) m <= '0;
    else m <= step(m, reg_update, reg_addr_q, reg_q, bus_if.req_ready,
                   bus_if.rsp_valid, bus_if.rsp_rdata, bus_if.rsp_err);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(negedge jtck) begin
    if (jrstn) begin
      chk("req_valid", 32'(bus_if.req_valid), 32'(m.phase == 2'd1));
      if (m.phase == 2'd1) begin
        chk("req_addr", bus_if.req_addr, m.req_addr);
        chk("req_wdata", bus_if.req_wdata, m.req_wdata);
        chk("req_we", 32'(bus_if.req_we), 32'(m.we));
      end
      chk("reg_d", 32'(reg_d), 32'(m.sel3 ? m.rd_byte : mstatus(m)));
      chk("reg_addr_d", 32'(reg_addr_d), m.sel3 ? 32'd3 : 32'd0);
    end
  end

  task automatic tick();
    @(posedge jtck);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] q);
    reg_update = 1'b1; reg_addr_q = a; reg_q = q;
    tick();
    reg_update = 1'b0;
    $display("host write addr=%0d data=%h -> reg_d=%h reg_addr_d=%0d", a, q, reg_d, reg_addr_d);
  endtask

  task automatic bus_txn(input int rdy_dly, input int rsp_dly, input logic [31:0] rd, input logic er);
    repeat (rdy_dly) tick();
    bus_if.req_ready = 1'b1;
    tick();
    bus_if.req_ready = 1'b0;
    repeat (rsp_dly) tick();
    bus_if.rsp_valid = 1'b1; bus_if.rsp_rdata = rd; bus_if.rsp_err = er;
    tick();
    bus_if.rsp_valid = 1'b0; bus_if.rsp_err = 1'b0;
    $display("bus txn ready_delay=%0d rsp_delay=%0d rdata=%h err=%b -> status=%h",
             rdy_dly, rsp_dly, rd, er, reg_d);
  endtask

  int vcnt;

  initial begin
    jrstn = 1'b0; reg_update = 1'b0; reg_q = 8'h00; reg_addr_q = 3'd0;
    bus_if.req_ready = 1'b0; bus_if.rsp_valid = 1'b0;
    bus_if.rsp_rdata = 32'h0; bus_if.rsp_err = 1'b0;
    #2;
    chk("rst reg_d", 32'(reg_d), 32'h0);
    chk("rst reg_addr_d", 32'(reg_addr_d), 32'h0);
    chk("rst req_valid", 32'(bus_if.req_valid), 32'h0);
    repeat (2) tick();
    jrstn = 1'b1;
    tick();

    // T1 write; addr 5 must not disturb the address shift register
    wr(3'd1, 8'h12); wr(3'd1, 8'h34); wr(3'd5, 8'h99); wr(3'd1, 8'h56); wr(3'd1, 8'h78);
    wr(3'd2, 8'hDE); wr(3'd2, 8'hAD); wr(3'd2, 8'hBE); wr(3'd2, 8'hEF);
    wr(3'd0, 8'h02);
    chk("T1 req_valid", 32'(bus_if.req_valid), 32'h1);
    chk("T1 req_addr", bus_if.req_addr, 32'h12345678);
    chk("T1 req_wdata", bus_if.req_wdata, 32'hDEADBEEF);
    chk("T1 req_we", 32'(bus_if.req_we), 32'h1);
    bus_txn(2, 4, 32'h0, 1'b0);  // response lands on the timeout cycle
    chk("T1 status", 32'(reg_d), 32'h42);

    // T2 read and byte readback
    wr(3'd0, 8'h01);
    bus_txn(1, 1, 32'hCAFEF00D, 1'b0);
    chk("T2 status", 32'(reg_d), 32'h41);
    wr(3'd3, 8'h00);
    chk("T2 byte0", 32'(reg_d), 32'h0D);
    chk("T2 reg_addr_d", 32'(reg_addr_d), 32'h3);
    wr(3'd3, 8'h03);
    chk("T2 byte3", 32'(reg_d), 32'hCA);

    // T3 timeout with req_ready never asserted
    wr(3'd0, 8'h01);
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus_if.req_valid) vcnt++;
      tick();
    end
    chk("T3 req_valid cycles", 32'(vcnt), 32'd8);
    chk("T3 status", 32'(reg_d), 32'h31);

    // T4 overrun, abort, clear
    wr(3'd0, 8'h01);
    wr(3'd1, 8'hAA);
    chk("T4 ovr status", 32'(reg_d), 32'h89);
    wr(3'd0, 8'h04);
    chk("T4 abort req_valid", 32'(bus_if.req_valid), 32'h0);
    chk("T4 abort status", 32'(reg_d), 32'h09);
    wr(3'd0, 8'h08);
    chk("T4 clr status", 32'(reg_d), 32'h01);
    wr(3'd0, 8'h02);
    chk("T4 addr kept", bus_if.req_addr, 32'h12345678);
    bus_txn(0, 0, 32'h0, 1'b0);

    // T5 bus error, stray response, bad command, handshake at timeout boundary
    wr(3'd0, 8'h02);
    bus_txn(1, 2, 32'h0, 1'b1);
    chk("T5 buserr status", 32'(reg_d), 32'h46);
    bus_if.rsp_valid = 1'b1; bus_if.rsp_rdata = 32'hFFFFFFFF;
    tick();
    bus_if.rsp_valid = 1'b0;
    tick();
    chk("T5 stray status", 32'(reg_d), 32'h46);
    wr(3'd3, 8'h01);
    chk("T5 rdata kept", 32'(reg_d), 32'hF0);
    wr(3'd0, 8'h10);
    chk("T5 badcmd status", 32'(reg_d), 32'h66);
    wr(3'd0, 8'h01);
    bus_txn(7, 0, 32'h11223344, 1'b0);  // accept on the timeout cycle
    chk("T5 tie status", 32'(reg_d), 32'h41);
    wr(3'd3, 8'h02);
    chk("T5 tie byte2", 32'(reg_d), 32'h22);

    // Asynchronous reset while a request is pending
    wr(3'd0, 8'h01);
    tick();
    #2;
    jrstn = 1'b0;
    #1;
    chk("rst req_valid async", 32'(bus_if.req_valid), 32'h0);
    chk("rst req_addr", bus_if.req_addr, 32'h0);
    chk("rst req_wdata", bus_if.req_wdata, 32'h0);
    chk("rst req_we", 32'(bus_if.req_we), 32'h0);
    chk("rst reg_d async", 32'(reg_d), 32'h0);
    chk("rst reg_addr_d async", 32'(reg_addr_d), 32'h0);
    #3;
    jrstn = 1'b1;
    tick();
    chk("post-rst status", 32'(reg_d), 32'h0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
